// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM pipeline front end.
// Provides the fetch/decode pipeline payload, reset/bubble constants and
// a word-alignment helper for PC targets.
package arm_pipe_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'hE1A0_0000;  // MOV R0,R0 (AL)

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pcplus4;
    logic [XLEN-1:0] pcplus8;
    logic            valid;
  } fd_reg_t;

  localparam fd_reg_t FD_BUBBLE = '{
    instr:   NOP_INSTR,
    pcplus4: '0,
    pcplus8: '0,
    valid:   1'b0
  };

  // Instruction addresses are word aligned; drop the byte offset.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fd_pipe_reg.sv
// Fetch-to-decode pipeline register.
// Priority: reset/flush -> bubble, stall -> hold, load -> capture, else bubble.
// Ports: clk, reset (sync, active-high), flush, stall, load, d (payload in),
//        q (registered payload out).
module fd_pipe_reg
  import arm_pipe_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    flush,
  input  logic    stall,
  input  logic    load,
  input  fd_reg_t d,
  output fd_reg_t q
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      q <= FD_BUBBLE;
    end else if (stall) begin
      q <= q;
    end else if (load) begin
      q <= d;
    end else begin
      // No instruction arrived this cycle: insert exactly one bubble.
      q <= FD_BUBBLE;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, selects the next PC (branch > PC write > +4),
// drives instruction memory and fills the fetch-to-decode register.
// Ports: clk, reset (sync, active-high); hazard controls stall_f, stall_d,
//        flush_d; redirects branch_taken_e/branch_target_e and
//        pc_src_w/result_w; imem_addr/imem_rdata/imem_ready memory port;
//        decode outputs instr_d, pcplus4_d, pcplus8_d, valid_d; fetch_wait.
module fetch_stage
  import arm_pipe_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_f,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            branch_taken_e,
  input  logic [XLEN-1:0] branch_target_e,
  input  logic            pc_src_w,
  input  logic [XLEN-1:0] result_w,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ready,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pcplus4_d,
  output logic [XLEN-1:0] pcplus8_d,
  output logic            valid_d,
  output logic            fetch_wait
);

  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] pcplus4_c;
  logic [XLEN-1:0] pcplus8_c;
  logic [XLEN-1:0] pc_next_c;
  logic            redirect_c;
  logic            fetch_ok_c;
  logic            pc_load_c;
  fd_reg_t         fd_d_c;
  fd_reg_t         fd_q;

  // Next-PC selection; a redirect overrides stalls and memory wait states.
  always_comb begin
    pcplus4_c  = pc_f + XLEN'(4);
    pcplus8_c  = pc_f + XLEN'(8);
    redirect_c = branch_taken_e | pc_src_w;
    fetch_ok_c = imem_ready & ~stall_f;
    pc_load_c  = redirect_c | fetch_ok_c;
    pc_next_c  = pcplus4_c;
    if (branch_taken_e) begin
      pc_next_c = word_align(branch_target_e);
    end else if (pc_src_w) begin
      pc_next_c = word_align(result_w);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f <= RESET_PC;
    end else if (pc_load_c) begin
      pc_f <= pc_next_c;
    end
  end

  always_comb begin
    fd_d_c         = FD_BUBBLE;
    fd_d_c.instr   = imem_rdata;
    fd_d_c.pcplus4 = pcplus4_c;
    fd_d_c.pcplus8 = pcplus8_c;
    fd_d_c.valid   = 1'b1;
  end

  fd_pipe_reg u_fd_pipe_reg (
    .clk   (clk),
    .reset (reset),
    .flush (flush_d),
    .stall (stall_d),
    .load  (fetch_ok_c),
    .d     (fd_d_c),
    .q     (fd_q)
  );

  assign imem_addr  = pc_f;
  assign fetch_wait = ~imem_ready;
  assign instr_d    = fd_q.instr;
  assign pcplus4_d  = fd_q.pcplus4;
  assign pcplus8_d  = fd_q.pcplus8;
  assign valid_d    = fd_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed stimulus, a behavioural
// model of PC and decode contents, a per-cycle compare process and a set of
// literal expectations that pin the model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall_f, stall_d, flush_d;
  logic        branch_taken_e, pc_src_w, imem_ready;
  logic [31:0] branch_target_e, result_w, imem_rdata, imem_addr;
  logic [31:0] instr_d, pcplus4_d, pcplus8_d;
  logic        valid_d, fetch_wait;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Model state: what the decode stage and PC must hold after each edge.
  logic [31:0] m_pc, m_instr, m_p4, m_p8;
  logic        m_valid;

  always #5 clk = ~clk;

  // Instruction memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hE04F_000F;
      32'h0000_0004: return 32'hE280_2005;
      default:       return {8'hE3, a[23:0]} ^ 32'h0055_0000;
    endcase
  endfunction

  assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .branch_taken_e(branch_taken_e),
    .branch_target_e(branch_target_e), .pc_src_w(pc_src_w),
    .result_w(result_w), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .instr_d(instr_d), .pcplus4_d(pcplus4_d),
    .pcplus8_d(pcplus8_d), .valid_d(valid_d), .fetch_wait(fetch_wait)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model, away from the rising edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("fetch_wait", 32'(fetch_wait), 32'(!imem_ready));
      chk("instr_d", instr_d, m_instr);
      chk("pcplus4_d", pcplus4_d, m_p4);
      chk("pcplus8_d", pcplus8_d, m_p8);
      chk("valid_d", 32'(valid_d), 32'(m_valid));
    end
  end

  // Apply one cycle of inputs, advance the model across the edge.
  task automatic step(input bit rst, input bit rdy, input bit sf, input bit sd,
                      input bit fl, input bit br, input logic [31:0] tgt,
                      input bit pw, input logic [31:0] res);
    logic [31:0] n_pc, n_instr, n_p4, n_p8;
    logic        n_valid;
    reset = rst; imem_ready = rdy; stall_f = sf; stall_d = sd; flush_d = fl;
    branch_taken_e = br; branch_target_e = tgt; pc_src_w = pw; result_w = res;
    // PC: redirect always wins, sequential advance only when a word arrived.
    if (rst)             n_pc = 32'h0;
    else if (br)         n_pc = tgt & ~32'h3;
    else if (pw)         n_pc = res & ~32'h3;
    else if (rdy && !sf) n_pc = m_pc + 32'd4;
    else                 n_pc = m_pc;
    // Decode register contents.
    {n_instr, n_p4, n_p8, n_valid} = {32'hE1A0_0000, 32'h0, 32'h0, 1'b0};
    if (!rst && !fl) begin
      if (sd) {n_instr, n_p4, n_p8, n_valid} = {m_instr, m_p4, m_p8, m_valid};
      else if (rdy && !sf)
        {n_instr, n_p4, n_p8, n_valid} = {mem_word(m_pc), m_pc + 32'd4, m_pc + 32'd8, 1'b1};
    end
    @(posedge clk);
    #1;
    {m_pc, m_instr, m_p4, m_p8, m_valid} = {n_pc, n_instr, n_p4, n_p8, n_valid};
    check_en = 1'b1;
  endtask

  task automatic run(input bit rdy, input bit sf, input bit sd, input bit fl);
    step(1'b0, rdy, sf, sd, fl, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic redirect(input bit br, input logic [31:0] tgt, input bit pw,
                          input logic [31:0] res);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, br, tgt, pw, res);
  endtask

  logic [31:0] held;

  initial begin
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr_d, 32'hE1A0_0000);
    chk("rst_valid", 32'(valid_d), 32'h0);
    chk("rst_p8", pcplus8_d, 32'h0);

    // Sequential fetch from 0.
    run(1'b1, 1'b0, 1'b0, 1'b0);
    chk("seq0_instr", instr_d, 32'hE04F_000F);
    chk("seq0_p4", pcplus4_d, 32'h4);
    chk("seq0_p8", pcplus8_d, 32'h8);
    run(1'b1, 1'b0, 1'b0, 1'b0);
    chk("seq1_instr", instr_d, 32'hE280_2005);
    chk("seq1_p8", pcplus8_d, 32'hC);
    run(1'b1, 1'b0, 1'b0, 1'b0);
    run(1'b1, 1'b0, 1'b0, 1'b0);
    chk("pc_10", imem_addr, 32'h10);

    // Three-cycle full stall at 0x10.
    held = instr_d;
    for (int i = 0; i < 3; i++) begin
      run(1'b1, 1'b1, 1'b1, 1'b0);
      chk("stall_addr", imem_addr, 32'h10);
      chk("stall_hold", instr_d, held);
    end
    run(1'b1, 1'b0, 1'b0, 1'b0);
    chk("resume_p4", pcplus4_d, 32'h14);

    // Branch beats PC write in the same cycle.
    redirect(1'b1, 32'h40, 1'b1, 32'h80);
    chk("br_pc", imem_addr, 32'h40);
    chk("br_flush", 32'(valid_d), 32'h0);
    run(1'b1, 1'b0, 1'b0, 1'b0);
    chk("br_p4", pcplus4_d, 32'h44);

    // Flush beats stall.
    run(1'b1, 1'b1, 1'b1, 1'b1);
    chk("fl_instr", instr_d, 32'hE1A0_0000);
    chk("fl_p4", pcplus4_d, 32'h0);

    // Memory wait states at 0x20, then redirect during a wait.
    redirect(1'b0, 32'h0, 1'b1, 32'h20);
    run(1'b1, 1'b0, 1'b0, 1'b0);
    redirect(1'b0, 32'h0, 1'b1, 32'h20);
    run(1'b0, 1'b0, 1'b0, 1'b0);
    chk("wait_pc", imem_addr, 32'h20);
    chk("wait_bubble", 32'(valid_d), 32'h0);
    chk("wait_flag", 32'(fetch_wait), 32'h1);
    run(1'b0, 1'b0, 1'b0, 1'b0);
    run(1'b1, 1'b0, 1'b0, 1'b0);
    chk("wait_done_p4", pcplus4_d, 32'h24);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h103, 1'b0, 32'h0);
    chk("wait_redirect", imem_addr, 32'h100);
    run(1'b1, 1'b0, 1'b0, 1'b0);
    chk("tgt_p4", pcplus4_d, 32'h104);

    // Address wrap at the top of memory.
    redirect(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    run(1'b1, 1'b0, 1'b0, 1'b0);
    chk("wrap_p4", pcplus4_d, 32'h0);
    chk("wrap_p8", pcplus8_d, 32'h4);
    chk("wrap_pc", imem_addr, 32'h0);

    // Mixed pattern: decode-only stalls, fetch-only stalls, waits.
    for (int i = 0; i < 24; i++) begin
      run(1'(i % 5 != 3), 1'(i % 7 == 2), 1'(i % 6 == 4), 1'(i % 11 == 9));
    end

    // Reset mid-stream overrides everything.
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 32'h300);
    chk("mid_rst_pc", imem_addr, 32'h0);
    chk("mid_rst_instr", instr_d, 32'hE1A0_0000);
    run(1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_instr", instr_d, 32'hE04F_000F);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
